// File: rtl/mem_pkg.sv
// Shared encodings and lane helpers for the load/store front-end.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ_WAIT,
        ST_FINISH
    } state_t;

    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: return 4'b0001 << lo;
            SZ_HALF: return lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Size 11 is reserved and always rejected.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lo[0];
            SZ_WORD: return lo != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load lane select and sign/zero extension; purely combinational.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] iRaw,
    input  logic [1:0]  iLo,
    input  logic [1:0]  iSize,
    input  logic        iUnsigned,
    output logic [31:0] oData
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = iRaw[8*iLo +: 8];
        half_sel = iLo[1] ? iRaw[31:16] : iRaw[15:0];
        case (iSize)
            SZ_BYTE: oData = {{24{byte_sel[7] & ~iUnsigned}}, byte_sel};
            SZ_HALF: oData = {{16{half_sel[15] & ~iUnsigned}}, half_sel};
            default: oData = iRaw;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front-end: alignment check, bus strobes and lane steering, load return.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int ADDR_W = 32
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iReq,
    input  logic              iWrite,
    input  logic [1:0]        iSize,
    input  logic              iUnsigned,
    input  logic [ADDR_W-1:0] iAddr,
    input  logic [31:0]       iWData,
    output logic              oReady,
    output logic              oDone,
    output logic [31:0]       oRData,
    output logic              oMisaligned,
    output logic [ADDR_W-1:0] oBadAddr,
    output logic [ADDR_W-1:0] oBusAddr,
    output logic              oBusRE,
    output logic              oBusWE,
    output logic [3:0]        oBusByteEn,
    output logic [31:0]       oBusWData,
    input  logic [31:0]       iBusRData
);

    localparam logic [1:0] LAT = 2'(RD_LAT);

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [1:0]        lo_q, lo_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic              done_q, done_d;
    logic              mis_q, mis_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [ADDR_W-1:0] bad_q, bad_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic              re_q, re_d;
    logic              we_q, we_d;
    logic [3:0]        ben_q, ben_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       load_ext;
    logic [31:0]       wdata_lane;

    mem_load_align u_align (
        .iRaw      (iBusRData),
        .iLo       (lo_q),
        .iSize     (size_q),
        .iUnsigned (uns_q),
        .oData     (load_ext)
    );

    always_comb begin
        case (iSize)
            SZ_BYTE: wdata_lane = {4{iWData[7:0]}};
            SZ_HALF: wdata_lane = {2{iWData[15:0]}};
            default: wdata_lane = iWData;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lo_d       = lo_q;
        size_d     = size_q;
        uns_d      = uns_q;
        done_d     = 1'b0;
        mis_d      = 1'b0;
        rdata_d    = rdata_q;
        bad_d      = bad_q;
        bus_addr_d = bus_addr_q;
        re_d       = re_q;
        we_d       = we_q;
        ben_d      = ben_q;
        wdata_d    = wdata_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = 2'd0;
                if (iReq) begin
                    lo_d   = iAddr[1:0];
                    size_d = iSize;
                    uns_d  = iUnsigned;
                    if (is_misaligned(iSize, iAddr[1:0])) begin
                        state_d = ST_FINISH;
                        done_d  = 1'b1;
                        mis_d   = 1'b1;
                        bad_d   = iAddr;
                    end else begin
                        bus_addr_d = {iAddr[ADDR_W-1:2], 2'b00};
                        ben_d      = byte_enable(iSize, iAddr[1:0]);
                        if (iWrite) begin
                            we_d    = 1'b1;
                            wdata_d = wdata_lane;
                            state_d = ST_WRITE;
                        end else begin
                            re_d    = 1'b1;
                            state_d = ST_READ_WAIT;
                        end
                    end
                end
            end
            ST_WRITE: begin
                we_d    = 1'b0;
                ben_d   = 4'b0000;
                done_d  = 1'b1;
                state_d = ST_FINISH;
            end
            ST_READ_WAIT: begin
                // Strobe stays up through the capture cycle, then drops with done.
                if (cnt_q == LAT) begin
                    re_d    = 1'b0;
                    ben_d   = 4'b0000;
                    done_d  = 1'b1;
                    rdata_d = load_ext;
                    state_d = ST_FINISH;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            lo_q       <= '0;
            size_q     <= '0;
            uns_q      <= 1'b0;
            done_q     <= 1'b0;
            mis_q      <= 1'b0;
            rdata_q    <= '0;
            bad_q      <= '0;
            bus_addr_q <= '0;
            re_q       <= 1'b0;
            we_q       <= 1'b0;
            ben_q      <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lo_q       <= lo_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            done_q     <= done_d;
            mis_q      <= mis_d;
            rdata_q    <= rdata_d;
            bad_q      <= bad_d;
            bus_addr_q <= bus_addr_d;
            re_q       <= re_d;
            we_q       <= we_d;
            ben_q      <= ben_d;
            wdata_q    <= wdata_d;
        end
    end

    assign oReady      = (state_q == ST_IDLE);
    assign oDone       = done_q;
    assign oRData      = rdata_q;
    assign oMisaligned = mis_q;
    assign oBadAddr    = bad_q;
    assign oBusAddr    = bus_addr_q;
    assign oBusRE      = re_q;
    assign oBusWE      = we_q;
    assign oBusByteEn  = ben_q;
    assign oBusWData   = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Two instances (read latency 1 and 3) share stimulus; a cycle-offset model checks both.
module tb_mem_access_unit;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        iReq = 1'b0;
    logic        iWrite = 1'b0;
    logic [1:0]  iSize = 2'b00;
    logic        iUnsigned = 1'b0;
    logic [31:0] iAddr = '0;
    logic [31:0] iWData = '0;
    logic [31:0] iBusRData = '0;

    logic        rdy[2], done[2], mis[2], re[2], we[2];
    logic [3:0]  ben[2];
    logic [31:0] rdata[2], bad[2], baddr[2], wd[2];

    always #5 iCLK = ~iCLK;

    mem_access_unit #(.RD_LAT(1), .ADDR_W(32)) dut1 (
        .iCLK(iCLK), .iRST(iRST), .iReq(iReq), .iWrite(iWrite), .iSize(iSize),
        .iUnsigned(iUnsigned), .iAddr(iAddr), .iWData(iWData),
        .oReady(rdy[0]), .oDone(done[0]), .oRData(rdata[0]), .oMisaligned(mis[0]),
        .oBadAddr(bad[0]), .oBusAddr(baddr[0]), .oBusRE(re[0]), .oBusWE(we[0]),
        .oBusByteEn(ben[0]), .oBusWData(wd[0]), .iBusRData(iBusRData)
    );

    mem_access_unit #(.RD_LAT(3), .ADDR_W(32)) dut3 (
        .iCLK(iCLK), .iRST(iRST), .iReq(iReq), .iWrite(iWrite), .iSize(iSize),
        .iUnsigned(iUnsigned), .iAddr(iAddr), .iWData(iWData),
        .oReady(rdy[1]), .oDone(done[1]), .oRData(rdata[1]), .oMisaligned(mis[1]),
        .oBadAddr(bad[1]), .oBusAddr(baddr[1]), .oBusRE(re[1]), .oBusWE(we[1]),
        .oBusByteEn(ben[1]), .oBusWData(wd[1]), .iBusRData(iBusRData)
    );

    int total = 0;
    int bad_n = 0;

    task automatic chk(input string name, input int k, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad_n++;
            $display("FAIL %s dut%0d: got %h want %h at %0t", name, k, a, e, $time);
        end
    endtask

    // Model: per instance, the cycle number since acceptance decides every output.
    int          lat[2] = '{1, 3};
    bit          mvalid = 1'b0;
    bit          act[2], st[2], ld[2], ms[2], m_u[2];
    int          c[2], dl[2];
    logic [1:0]  m_lo[2], m_sz[2];
    logic [31:0] erd[2], ebad[2], eba[2], ewd[2];

    function automatic bit idle(input int k);
        return !act[k] || (c[k] > dl[k]);
    endfunction

    function automatic bit m_misal(input logic [1:0] sz, input logic [1:0] lo);
        return (sz == 2'd3) || (sz == 2'd1 && lo[0]) || (sz == 2'd2 && lo != 2'd0);
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] lo);
        if (sz == 2'd0) return 4'b0001 << lo;
        if (sz == 2'd1) return 4'b0011 << lo;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] m_rep(input logic [1:0] sz, input logic [31:0] w);
        if (sz == 2'd0) return (w & 32'hFF) * 32'h0101_0101;
        if (sz == 2'd1) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] m_ext(input logic [31:0] w, input logic [1:0] lo,
                                          input logic [1:0] sz, input bit u);
        logic [31:0] v;
        if (sz == 2'd2) return w;
        if (sz == 2'd0) begin
            v = (w >> (8 * int'(lo))) & 32'hFF;
            if (!u && v[7]) v = v | 32'hFFFF_FF00;
        end else begin
            v = (w >> (16 * int'(lo[1]))) & 32'hFFFF;
            if (!u && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    always @(posedge iCLK) begin
        if (iRST) begin
            mvalid = 1'b1;
            for (int k = 0; k < 2; k++) begin
                act[k] = 1'b0; c[k] = 0; dl[k] = 0;
                erd[k] = '0; ebad[k] = '0; eba[k] = '0; ewd[k] = '0;
            end
        end else if (mvalid) begin
            for (int k = 0; k < 2; k++) begin
                if (idle(k) && iReq) begin
                    act[k]  = 1'b1;
                    c[k]    = 1;
                    ms[k]   = m_misal(iSize, iAddr[1:0]);
                    st[k]   = iWrite && !ms[k];
                    ld[k]   = !iWrite && !ms[k];
                    dl[k]   = ms[k] ? 1 : (st[k] ? 2 : 2 + lat[k]);
                    m_lo[k] = iAddr[1:0];
                    m_sz[k] = iSize;
                    m_u[k]  = iUnsigned;
                    if (ms[k]) ebad[k] = iAddr;
                    else eba[k] = iAddr & 32'hFFFF_FFFC;
                    if (st[k]) ewd[k] = m_rep(iSize, iWData);
                end else if (act[k]) begin
                    if (c[k] < 1000) c[k]++;
                    if (ld[k] && c[k] == dl[k]) erd[k] = m_ext(iBusRData, m_lo[k], m_sz[k], m_u[k]);
                end
            end
        end
    end

    always @(negedge iCLK) begin
        if (mvalid) begin
            for (int k = 0; k < 2; k++) begin
                bit e_we, e_re, e_done;
                e_we   = act[k] && st[k] && c[k] == 1;
                e_re   = act[k] && ld[k] && c[k] >= 1 && c[k] <= 1 + lat[k];
                e_done = act[k] && c[k] == dl[k];
                chk("ready", k, 32'(rdy[k]), 32'(idle(k)));
                chk("we", k, 32'(we[k]), 32'(e_we));
                chk("re", k, 32'(re[k]), 32'(e_re));
                chk("done", k, 32'(done[k]), 32'(e_done));
                chk("misaligned", k, 32'(mis[k]), 32'(e_done && ms[k]));
                chk("byteen", k, 32'(ben[k]), (e_we || e_re) ? 32'(m_be(m_sz[k], m_lo[k])) : 32'd0);
                chk("rdata", k, rdata[k], erd[k]);
                chk("badaddr", k, bad[k], ebad[k]);
                chk("busaddr", k, baddr[k], eba[k]);
                chk("buswdata", k, wd[k], ewd[k]);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge iCLK);
        #1;
    endtask

    // Waits until both instances are idle, then presents one request for one edge.
    task automatic issue(input bit w, input logic [1:0] sz, input bit u, input logic [31:0] a,
                         input logic [31:0] wdat, input logic [31:0] bus);
        int n;
        n = 0;
        while (!(idle(0) && idle(1)) && n < 100) begin
            step(1);
            n++;
        end
        if (n >= 100) begin
            total++;
            bad_n++;
            $display("FAIL idle_wait: got busy after %0d cycles want idle", n);
        end
        iWrite = w; iSize = sz; iUnsigned = u; iAddr = a; iWData = wdat; iBusRData = bus;
        iReq = 1'b1;
        step(1);
        iReq = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step(2);
        iRST = 1'b0;
        step(1);
        chk("lit_ready_after_reset", 0, 32'(rdy[0]), 32'd1);
        chk("lit_rdata_reset", 0, rdata[0], 32'h0);

        issue(1'b1, 2'b00, 1'b0, 32'h1001_0003, 32'h0000_00AB, 32'h0);
        chk("lit_sb_we", 0, 32'(we[0]), 32'd1);
        chk("lit_sb_ben", 0, 32'(ben[0]), 32'h8);
        chk("lit_sb_wdata", 0, wd[0], 32'hABAB_ABAB);
        chk("lit_sb_addr", 0, baddr[0], 32'h1001_0000);
        step(1);
        chk("lit_sb_done", 0, 32'(done[0]), 32'd1);

        issue(1'b0, 2'b01, 1'b0, 32'h1001_0002, 32'h0, 32'h8001_1234);
        step(2);
        chk("lit_lh_done", 0, 32'(done[0]), 32'd1);
        chk("lit_lh_rdata", 0, rdata[0], 32'hFFFF_8001);
        issue(1'b0, 2'b01, 1'b1, 32'h1001_0002, 32'h0, 32'h8001_1234);
        step(2);
        chk("lit_lhu_rdata", 0, rdata[0], 32'h0000_8001);

        issue(1'b0, 2'b00, 1'b0, 32'h1001_0001, 32'h0, 32'h0000_F000);
        chk("lit_lb_re_c1", 0, 32'(re[0]), 32'd1);
        step(1);
        chk("lit_lb_re_c2", 0, 32'(re[0]), 32'd1);
        step(1);
        chk("lit_lb_re_c3", 0, 32'(re[0]), 32'd0);
        chk("lit_lb_rdata", 0, rdata[0], 32'hFFFF_FFF0);

        issue(1'b0, 2'b10, 1'b0, 32'h1001_0006, 32'h0, 32'h0);
        chk("lit_mis_done", 0, 32'(done[0]), 32'd1);
        chk("lit_mis_flag", 0, 32'(mis[0]), 32'd1);
        chk("lit_mis_bad", 0, bad[0], 32'h1001_0006);
        chk("lit_mis_re", 0, 32'(re[0]), 32'd0);

        issue(1'b0, 2'b10, 1'b0, 32'h1001_0008, 32'h0, 32'hDEAD_BEEF);
        step(3);
        chk("lit_lw3_c4_done", 1, 32'(done[1]), 32'd0);
        step(1);
        chk("lit_lw3_c5_done", 1, 32'(done[1]), 32'd1);
        chk("lit_lw3_rdata", 1, rdata[1], 32'hDEAD_BEEF);

        issue(1'b1, 2'b01, 1'b0, 32'h1001_0002, 32'h1234_5678, 32'h0);
        chk("lit_sh_ben", 0, 32'(ben[0]), 32'hC);
        chk("lit_sh_wdata", 0, wd[0], 32'h5678_5678);
        issue(1'b1, 2'b10, 1'b0, 32'h1001_000C, 32'hCAFE_F00D, 32'h0);
        issue(1'b0, 2'b01, 1'b1, 32'h1001_0000, 32'h0, 32'h1234_FFEE);
        step(2);
        chk("lit_lhu0_rdata", 0, rdata[0], 32'h0000_FFEE);
        issue(1'b1, 2'b11, 1'b0, 32'h1001_0000, 32'h5555_5555, 32'h0);
        issue(1'b0, 2'b00, 1'b1, 32'h1001_0003, 32'h0, 32'h9A00_0000);
        issue(1'b1, 2'b01, 1'b0, 32'h1001_0001, 32'h7777_7777, 32'h0);

        issue(1'b0, 2'b10, 1'b0, 32'h1001_0010, 32'h0, 32'h1111_1111);
        chk("lit_rst_pre_re", 0, 32'(re[0]), 32'd1);
        iRST = 1'b1;
        step(1);
        iRST = 1'b0;
        chk("lit_rst_re0", 0, 32'(re[0]), 32'd0);
        chk("lit_rst_re1", 1, 32'(re[1]), 32'd0);
        chk("lit_rst_ready", 0, 32'(rdy[0]), 32'd1);
        chk("lit_rst_done", 0, 32'(done[0]), 32'd0);
        step(4);
        issue(1'b0, 2'b00, 1'b0, 32'h1001_0002, 32'h0, 32'h0042_0000);
        step(2);
        chk("lit_post_rst_rdata", 0, rdata[0], 32'h0000_0042);

        issue(1'b1, 2'b00, 1'b0, 32'h1001_0000, 32'h0000_0011, 32'h0);
        step(6);
        $display("test done: total=%0d bad=%0d", total, bad_n);
        $finish;
    end

endmodule
